alu_mc: RTL
===========

# alu_mc

Multi-cycle, width-parametrised ALU for the next-generation RISC-V datapath. It executes ADD/SUB/AND/OR in one cycle and MUL as an iterative shift-add over several cycles. A valid/ready handshake lets the PC and pipeline stall while a multiply is in flight. It sits between the operand MUX (immediate/RS2 select) and the MEM/ALU writeback MUX, and adds registered outputs, a stall handshake and a flush that the single-cycle ALU lacks.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1, multiplier bits consumed per MUL step; S = WIDTH/BITS_PER_CYCLE steps.

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  1  operation request.
- ready_o  out  1  block can accept a request this cycle.
- flush_i  in  1  abort in-flight operation (branch taken).
- ALU_Ctrl_i  in  3  op code: ADD 010, SUB 110, MUL 011, AND 000, OR 001.
- data1_i  in  WIDTH  operand 1.
- data2_i  in  WIDTH  operand 2.
- valid_o  out  1  one-cycle pulse: data_o/Zero_o hold a new result.
- data_o  out  WIDTH  registered result.
- Zero_o  out  1  registered (data_o == 0).

## Operation
- States: IDLE, MUL.
- ready_o = (state == IDLE). Accept = valid_i && ready_o && !flush_i, sampled at the rising edge.
- IDLE, accept, non-MUL op:
  - Compute the result.
  - Register data_o and Zero_o.
  - valid_o = 1 next cycle.
  - Stay in IDLE.
- IDLE, accept, MUL:
  - Latch multiplicand = data1_i and multiplier = data2_i.
  - Clear accumulator; set count = S.
  - Go to MUL.
- MUL, each edge:
  - accumulator += multiplicand × (low BITS_PER_CYCLE bits of multiplier).
  - Multiplicand shifts left by BITS_PER_CYCLE; multiplier shifts right by BITS_PER_CYCLE.
  - count decrements.
  - On the step where count == 1: write the accumulator to data_o, update Zero_o, pulse valid_o, go to IDLE.
- Arithmetic is modulo 2^WIDTH:
  - ADD/SUB wrap.
  - MUL returns the low WIDTH bits of the unsigned/two's-complement product; the low half is identical for both.
- Unknown op code: data_o = 0, Zero_o = 1, valid_o pulses; single-cycle.
- valid_i while in MUL: ignored (ready_o = 0); no queueing.
- flush_i:
  - In IDLE: the request that cycle is dropped.
  - In MUL: go to IDLE next edge with no valid_o, including on the final step.
  - data_o/Zero_o keep their last values.
- valid_o is 0 on every cycle not listed above; data_o/Zero_o hold between results.
- rst_i (wins over everything, mid-MUL included): state IDLE, data_o = 0, Zero_o = 1, valid_o = 0, count = 0, ready_o = 1 in the cycle after reset.

## Timing
- Request accepted at edge k.
- Single-cycle op: valid_o/data_o visible in cycle k+1; latency 1; back-to-back issue every cycle.
- MUL:
  - Steps at edges k+1 … k+S.
  - ready_o low in cycles k+1 … k+S.
  - valid_o and ready_o high in cycle k+S+1; latency S+1.
  - A new request is accepted at edge k+S+1.
- All outputs are registered; no combinational path from inputs to data_o/Zero_o/valid_o. ready_o depends only on state.

## Configuration
- ALU_MUL_EN defined: MUL (011) runs the multi-cycle path above.
- ALU_MUL_EN undefined:
  - MUL state, multiplier datapath and counter are compiled out.
  - 011 is treated as an unknown op (data_o = 0, Zero_o = 1, latency 1).
  - ready_o is tied 1.

## Structure
- Shared package alu_mc_pkg holds:
  - ALU_Ctrl constants (ADD, SUB, MUL, AND, OR).
  - State enum (IDLE, MUL).
  - The 3-bit op-code width constant.
- Sub-module mul_step: combinational single shift-add iteration, parametrised by WIDTH and BITS_PER_CYCLE. The top level holds the state, counter and output registers.

## Test plan
All scenarios use WIDTH = 32, BITS_PER_CYCLE = 1, ALU_MUL_EN defined.
- Reset: hold rst_i 2 cycles → data_o = 0, Zero_o = 1, valid_o = 0, ready_o = 1.
- ADD 5 + 7, then SUB 3 − 3 on consecutive cycles → valid_o pulses in two consecutive cycles; data_o = 12, Zero_o = 0, then data_o = 0, Zero_o = 1.
- MUL 6 × 7 at edge k:
  - ready_o low for 32 cycles.
  - valid_o only in cycle k+33 with data_o = 42.
  - An ADD held on valid_i during the busy window is not accepted until cycle k+33.
- MUL 0xFFFFFFFF × 2 → data_o = 0xFFFFFFFE; MUL 0x80000000 × 2 → data_o = 0, Zero_o = 1.
- Flush during MUL: assert flush_i at cycle k+10 → no valid_o, ready_o = 1 next cycle, data_o keeps its previous value; a following ADD 1 + 1 returns 2.
- Reset during MUL at cycle k+20 → reset values next cycle, no valid_o; undefine ALU_MUL_EN and issue op 011 → data_o = 0, valid_o at k+1.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the alu_mc multi-cycle ALU.
//   - ALU_Ctrl op-code width and op-code constants (ADD, SUB, MUL, AND, OR)
//   - FSM state enum (IDLE, MUL)
package alu_mc_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_MUL = 3'b011;
  localparam logic [OP_W-1:0] OP_SUB = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mc_mul_step.sv
// One combinational shift-add multiply iteration.
//   acc_i     : running accumulator
//   mcand_i   : multiplicand, already shifted for this step
//   mplier_i  : multiplier, already shifted; low BITS_PER_CYCLE bits are consumed
//   acc_o     : acc_i + mcand_i * mplier_i[BITS_PER_CYCLE-1:0] (mod 2^WIDTH)
//   mcand_o   : mcand_i << BITS_PER_CYCLE
//   mplier_o  : mplier_i >> BITS_PER_CYCLE
module mul_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0] mplier_o
);

  logic [WIDTH-1:0] digit;

  // Zero-extend the consumed multiplier digit so the product stays WIDTH bits.
  assign digit    = {{(WIDTH-BITS_PER_CYCLE){1'b0}}, mplier_i[BITS_PER_CYCLE-1:0]};
  assign acc_o    = acc_i + (mcand_i * digit);
  assign mcand_o  = mcand_i << BITS_PER_CYCLE;
  assign mplier_o = mplier_i >> BITS_PER_CYCLE;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: ADD/SUB/AND/OR in one cycle, MUL as iterative shift-add.
// Optional feature macro: ALU_MUL_EN (when undefined, op 011 behaves as an
// unknown op, the MUL datapath is removed and ready_o is tied high).
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i / ready_o   request handshake: a request is accepted on a rising
//                       edge where valid_i && ready_o && !flush_i; ready_o
//                       depends only on FSM state, no request is queued
//   flush_i             drops the request this cycle / aborts an in-flight MUL
//   ALU_Ctrl_i          op code
//   data1_i, data2_i    operands
//   valid_o             one-cycle pulse with a new data_o/Zero_o
//   data_o, Zero_o      registered result and zero flag
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             flush_i,
  input  logic [OP_W-1:0]  ALU_Ctrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);

  if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_cfg_check
    $error("alu_mc: WIDTH must be a multiple of BITS_PER_CYCLE");
  end

  logic             accept;
  logic [WIDTH-1:0] alu_d;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             valid_q;

  // Single-cycle result; unknown codes (and MUL, which the FSM intercepts
  // when enabled) give 0.
  always_comb begin
    alu_d = '0;
    case (ALU_Ctrl_i)
      OP_ADD:  alu_d = data1_i + data2_i;
      OP_SUB:  alu_d = data1_i - data2_i;
      OP_AND:  alu_d = data1_i & data2_i;
      OP_OR:   alu_d = data1_i | data2_i;
      default: alu_d = '0;
    endcase
  end

  assign accept  = valid_i && ready_o && !flush_i;
  assign data_o  = data_q;
  assign Zero_o  = zero_q;
  assign valid_o = valid_q;

`ifdef ALU_MUL_EN
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [WIDTH-1:0] acc_d, mcand_d, mplier_d;

  mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_mul_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_d),
    .mcand_o  (mcand_d),
    .mplier_o (mplier_d)
  );

  assign ready_o = (state_q == ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      data_q   <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (ALU_Ctrl_i == OP_MUL) begin
              mcand_q  <= data1_i;
              mplier_q <= data2_i;
              acc_q    <= '0;
              cnt_q    <= CNT_W'(STEPS);
              state_q  <= ST_MUL;
            end else begin
              data_q  <= alu_d;
              zero_q  <= (alu_d == '0);
              valid_q <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (flush_i) begin
            // Abort wins even on the final step: no result is published.
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              data_q  <= acc_d;
              zero_q  <= (acc_d == '0);
              valid_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
`else
  assign ready_o = 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        data_q  <= alu_d;
        zero_q  <= (alu_d == '0);
        valid_q <= 1'b1;
      end
    end
  end
`endif

endmodule
